// File: rtl/md_unit_param.sv
// Multiply/divide unit with HI/LO registers for the Execute stage.
// Results are computed at the start edge and committed after a per-class latency.
module md_unit_param #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic [WIDTH-1:0]   calc_hi;
    logic [WIDTH-1:0]   calc_lo;

    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic               div_zero;
    logic               div_ovf;
    logic [WIDTH-1:0]   safe_rt_s;
    logic [WIDTH-1:0]   safe_rt_u;
    logic [WIDTH-1:0]   quot_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   quot_u;
    logic [WIDTH-1:0]   rem_u;

    assign prod_s = $signed({{WIDTH{rs_val[WIDTH-1]}}, rs_val}) *
                    $signed({{WIDTH{rt_val[WIDTH-1]}}, rt_val});
    assign prod_u = {{WIDTH{1'b0}}, rs_val} * {{WIDTH{1'b0}}, rt_val};

    // The dividers never see zero or the overflowing pair; those cases are muxed in below.
    assign div_zero  = (rt_val == '0);
    assign div_ovf   = (rs_val == MOST_NEG) && (rt_val == '1);
    assign safe_rt_s = (div_zero || div_ovf) ? ONE : rt_val;
    assign safe_rt_u = div_zero ? ONE : rt_val;

    assign quot_s = $signed(rs_val) / $signed(safe_rt_s);
    assign rem_s  = $signed(rs_val) % $signed(safe_rt_s);
    assign quot_u = rs_val / safe_rt_u;
    assign rem_u  = rs_val % safe_rt_u;

    always_comb begin
        calc_hi = '0;
        calc_lo = '0;
        case (md_op)
            3'd0: {calc_hi, calc_lo} = prod_s;
            3'd1: {calc_hi, calc_lo} = prod_u;
            3'd2: begin
                if (div_zero) begin
                    calc_hi = rs_val;
                    calc_lo = '1;
                end else if (div_ovf) begin
                    calc_hi = '0;
                    calc_lo = rs_val;
                end else begin
                    calc_hi = rem_s;
                    calc_lo = quot_s;
                end
            end
            3'd3: begin
                if (div_zero) begin
                    calc_hi = rs_val;
                    calc_lo = '1;
                end else begin
                    calc_hi = rem_u;
                    calc_lo = quot_u;
                end
            end
            default: ;
        endcase
    end

    assign busy = (state == BUSY);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            res_hi <= '0;
            res_lo <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !cancel) begin
                        case (md_op)
                            3'd0, 3'd1: begin
                                res_hi <= calc_hi;
                                res_lo <= calc_lo;
                                cnt    <= CNT_W'(MUL_LAT);
                                state  <= BUSY;
                            end
                            3'd2, 3'd3: begin
                                res_hi <= calc_hi;
                                res_lo <= calc_lo;
                                cnt    <= CNT_W'(DIV_LAT);
                                state  <= BUSY;
                            end
                            3'd4: hi <= rs_val;
                            3'd5: lo <= rs_val;
                            default: ;
                        endcase
                    end
                end
                BUSY: begin
                    // A cancel on the final edge still suppresses the commit.
                    if (cancel) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            hi    <= res_hi;
                            lo    <= res_lo;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit_param.sv
// Directed bench for md_unit_param: a 32-bit default instance and an 8-bit short-latency
// instance are exercised in turn with hand-computed vectors.
module tb_md_unit_param;

    logic        clk = 1'b0;
    logic        reset;

    logic        start_a, cancel_a;
    logic [2:0]  op_a;
    logic [31:0] rs_a, rt_a;
    logic        busy_a, done_a;
    logic [31:0] hi_a, lo_a;

    logic        start_b, cancel_b;
    logic [2:0]  op_b;
    logic [7:0]  rs_b, rt_b;
    logic        busy_b, done_b;
    logic [7:0]  hi_b, lo_b;

    int    passed = 0;
    int    total  = 0;
    string pfx    = "w32";

    md_unit_param dut_a (
        .clk(clk), .reset(reset), .start(start_a), .md_op(op_a),
        .rs_val(rs_a), .rt_val(rt_a), .cancel(cancel_a),
        .busy(busy_a), .done(done_a), .hi(hi_a), .lo(lo_a)
    );

    md_unit_param #(.WIDTH(8), .MUL_LAT(1), .DIV_LAT(3)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .md_op(op_b),
        .rs_val(rs_b), .rt_val(rt_b), .cancel(cancel_b),
        .busy(busy_b), .done(done_b), .hi(hi_b), .lo(lo_b)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pk(input bit sel, input logic [31:0] v32, input logic [31:0] v8);
        return sel ? v8 : v32;
    endfunction

    function automatic logic [31:0] obs_busy(input bit sel);
        return sel ? {31'h0, busy_b} : {31'h0, busy_a};
    endfunction

    function automatic logic [31:0] obs_done(input bit sel);
        return sel ? {31'h0, done_b} : {31'h0, done_a};
    endfunction

    function automatic logic [31:0] obs_hi(input bit sel);
        return sel ? {24'h0, hi_b} : hi_a;
    endfunction

    function automatic logic [31:0] obs_lo(input bit sel);
        return sel ? {24'h0, lo_b} : lo_a;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("[TB] FAIL %s %s: observed %h expected %h", pfx, tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input bit sel, input logic st, input logic [2:0] op,
                                  input logic [31:0] rs, input logic [31:0] rt, input logic cn);
        if (!sel) begin
            start_a = st; op_a = op; rs_a = rs; rt_a = rt; cancel_a = cn;
        end else begin
            start_b = st; op_b = op; rs_b = rs[7:0]; rt_b = rt[7:0]; cancel_b = cn;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, scramble the operands while busy, then check latency, result and done pulse.
    task automatic run_op(input bit sel, input string tag, input logic [2:0] op,
                          input logic [31:0] rs, input logic [31:0] rt, input int lat,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        apply_stimulus(sel, 1'b1, op, rs, rt, 1'b0);
        tick();
        apply_stimulus(sel, 1'b0, 3'd6, ~rs, ~rt, 1'b0);
        check_output({tag, " busy"}, obs_busy(sel), 32'd1);
        n = 1;
        for (int k = 0; k < 40 && obs_busy(sel) == 32'd1; k++) begin
            tick();
            if (obs_busy(sel) == 32'd1) n++;
        end
        check_output({tag, " lat"}, 32'(n), 32'(lat));
        check_output({tag, " done"}, obs_done(sel), 32'd1);
        check_output({tag, " hi"}, obs_hi(sel), ehi);
        check_output({tag, " lo"}, obs_lo(sel), elo);
        tick();
        check_output({tag, " done drop"}, obs_done(sel), 32'd0);
    endtask

    task automatic cancel_test(input bit sel, input int cc);
        apply_stimulus(sel, 1'b1, 3'd4, 32'h11, 32'h0, 1'b0);
        tick();
        check_output("mthi busy", obs_busy(sel), 32'd0);
        check_output("mthi hi", obs_hi(sel), 32'h11);
        apply_stimulus(sel, 1'b1, 3'd5, 32'h22, 32'h0, 1'b0);
        tick();
        check_output("mtlo lo", obs_lo(sel), 32'h22);
        check_output("mtlo done", obs_done(sel), 32'd0);
        apply_stimulus(sel, 1'b1, 3'd6, 32'h99, 32'h99, 1'b0);
        tick();
        check_output("nop hi", obs_hi(sel), 32'h11);
        check_output("nop busy", obs_busy(sel), 32'd0);
        apply_stimulus(sel, 1'b1, 3'd3, 32'h7, 32'h2, 1'b0);
        tick();
        apply_stimulus(sel, 1'b0, 3'd6, 32'h0, 32'h0, 1'b0);
        repeat (cc - 1) tick();
        check_output("cancel pre busy", obs_busy(sel), 32'd1);
        apply_stimulus(sel, 1'b0, 3'd6, 32'h0, 32'h0, 1'b1);
        tick();
        apply_stimulus(sel, 1'b0, 3'd6, 32'h0, 32'h0, 1'b0);
        check_output("cancel busy", obs_busy(sel), 32'd0);
        check_output("cancel done", obs_done(sel), 32'd0);
        check_output("cancel hi", obs_hi(sel), 32'h11);
        check_output("cancel lo", obs_lo(sel), 32'h22);
        tick();
        check_output("cancel done later", obs_done(sel), 32'd0);
        check_output("cancel lo later", obs_lo(sel), 32'h22);
        apply_stimulus(sel, 1'b1, 3'd0, 32'h5, 32'h5, 1'b1);
        tick();
        apply_stimulus(sel, 1'b0, 3'd6, 32'h0, 32'h0, 1'b0);
        check_output("start+cancel busy", obs_busy(sel), 32'd0);
        tick();
        check_output("start+cancel lo", obs_lo(sel), 32'h22);
    endtask

    task automatic b2b_test(input bit sel, input int mlat, input int dlat);
        int e;
        apply_stimulus(sel, 1'b1, 3'd0, 32'hFFFFFFFD, 32'h5, 1'b0);
        tick();
        apply_stimulus(sel, 1'b1, 3'd3, 32'h7, 32'h2, 1'b0);
        tick();
        apply_stimulus(sel, 1'b0, 3'd6, 32'h0, 32'h0, 1'b0);
        e = 1;
        for (int k = 0; k < 40 && obs_done(sel) != 32'd1; k++) begin
            tick();
            e++;
        end
        check_output("b2b mult lat", 32'(e), 32'(mlat));
        check_output("b2b mult hi", obs_hi(sel), pk(sel, 32'hFFFFFFFF, 32'hFF));
        check_output("b2b mult lo", obs_lo(sel), pk(sel, 32'hFFFFFFF1, 32'hF1));
        apply_stimulus(sel, 1'b1, 3'd3, 32'h7, 32'h2, 1'b0);
        tick();
        apply_stimulus(sel, 1'b0, 3'd6, 32'h0, 32'h0, 1'b0);
        check_output("b2b divu busy", obs_busy(sel), 32'd1);
        e = 0;
        for (int k = 0; k < 40 && obs_done(sel) != 32'd1; k++) begin
            tick();
            e++;
        end
        check_output("b2b divu lat", 32'(e), 32'(dlat));
        check_output("b2b divu hi", obs_hi(sel), 32'h1);
        check_output("b2b divu lo", obs_lo(sel), 32'h3);
    endtask

    task automatic reset_test(input bit sel);
        apply_stimulus(sel, 1'b1, 3'd0, 32'hFFFFFFFD, 32'h5, 1'b0);
        tick();
        apply_stimulus(sel, 1'b0, 3'd6, 32'h0, 32'h0, 1'b0);
        check_output("rst pre busy", obs_busy(sel), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_output("rst busy", obs_busy(sel), 32'd0);
        check_output("rst done", obs_done(sel), 32'd0);
        check_output("rst hi", obs_hi(sel), 32'h0);
        check_output("rst lo", obs_lo(sel), 32'h0);
        tick();
        reset = 1'b1;
        tick();
        check_output("rst post busy", obs_busy(sel), 32'd0);
        check_output("rst post lo", obs_lo(sel), 32'h0);
    endtask

    task automatic run_suite(input bit sel);
        int ml;
        int dl;
        ml = sel ? 1 : 5;
        dl = sel ? 3 : 10;
        run_op(sel, "mult", 3'd0, 32'hFFFFFFFD, 32'h5, ml,
               pk(sel, 32'hFFFFFFFF, 32'hFF), pk(sel, 32'hFFFFFFF1, 32'hF1));
        run_op(sel, "multu", 3'd1, 32'hFFFFFFFD, 32'h5, ml,
               32'h4, pk(sel, 32'hFFFFFFF1, 32'hF1));
        run_op(sel, "divu 7/2", 3'd3, 32'h7, 32'h2, dl, 32'h1, 32'h3);
        run_op(sel, "div -7/2", 3'd2, 32'hFFFFFFF9, 32'h2, dl,
               pk(sel, 32'hFFFFFFFF, 32'hFF), pk(sel, 32'hFFFFFFFD, 32'hFD));
        run_op(sel, "div 7/-2", 3'd2, 32'h7, 32'hFFFFFFFE, dl,
               32'h1, pk(sel, 32'hFFFFFFFD, 32'hFD));
        run_op(sel, "div 9/0", 3'd2, 32'h9, 32'h0, dl,
               32'h9, pk(sel, 32'hFFFFFFFF, 32'hFF));
        run_op(sel, "divu 9/0", 3'd3, 32'h9, 32'h0, dl,
               32'h9, pk(sel, 32'hFFFFFFFF, 32'hFF));
        run_op(sel, "div ovf", 3'd2, pk(sel, 32'h80000000, 32'h80), 32'hFFFFFFFF, dl,
               32'h0, pk(sel, 32'h80000000, 32'h80));
        run_op(sel, "divu big", 3'd3, pk(sel, 32'h80000000, 32'h80), 32'hFFFFFFFF, dl,
               pk(sel, 32'h80000000, 32'h80), 32'h0);
        cancel_test(sel, sel ? 3 : 4);
        b2b_test(sel, ml, dl);
        reset_test(sel);
    endtask

    initial begin
        reset = 1'b0;
        apply_stimulus(1'b0, 1'b0, 3'd6, 32'h0, 32'h0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 3'd6, 32'h0, 32'h0, 1'b0);
        #2;
        pfx = "init";
        check_output("a busy", obs_busy(1'b0), 32'd0);
        check_output("a done", obs_done(1'b0), 32'd0);
        check_output("a hi", obs_hi(1'b0), 32'h0);
        check_output("a lo", obs_lo(1'b0), 32'h0);
        check_output("b busy", obs_busy(1'b1), 32'd0);
        check_output("b hi", obs_hi(1'b1), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        pfx = "w32";
        run_suite(1'b0);
        pfx = "w8";
        run_suite(1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
